// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: latches a byte plus framing configuration, forms the
// parity / 9th / 10th bits and serialises an 11-bit frame (start, d0..d6, bit9,
// bit10, stop) on tx at a programmable number of clocks per bit.
// Optional feature macro: UART_TX_HOLD_REG_EN adds a one-entry holding register
// in front of the shifter so back-to-back frames run with no idle gap.
module uart_tx_sequencer #(
    parameter int BAUD_W  = 20,
    parameter int FRAME_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [7:0]        data,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] baud_div,
    output logic              tx,
    output logic              txrdy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [BAUD_W-1:0] DIV_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
    localparam logic [BAUD_W-1:0] DIV_ZERO = {BAUD_W{1'b0}};
    localparam logic [3:0]        LAST_BIT = 4'(FRAME_W - 1);

    // Even parity over the active data bits (7 or 8).
    function automatic logic even_parity(input logic [7:0] d, input logic eight_bits);
        logic p;
        if (eight_bits) begin
            p = ^d[7:0];
        end else begin
            p = ^d[6:0];
        end
        return p;
    endfunction

    // Full frame image as loaded into the shifter; bit 0 leaves first.
    function automatic logic [10:0] build_frame(input logic [7:0] d, input logic eight_bits,
                                                input logic par_en, input logic odd);
        logic       ep;
        logic       op;
        logic [1:0] b10_b9;
        ep = even_parity(d, eight_bits);
        op = ~ep;
        case ({eight_bits, par_en, odd})
            3'b000, 3'b001: b10_b9 = 2'b11;
            3'b010:         b10_b9 = {1'b1, ep};
            3'b011:         b10_b9 = {1'b1, op};
            3'b100, 3'b101: b10_b9 = {1'b1, d[7]};
            3'b110:         b10_b9 = {ep, d[7]};
            3'b111:         b10_b9 = {op, d[7]};
            default:        b10_b9 = 2'b11;
        endcase
        return {1'b1, b10_b9, d[6:0], 1'b0};
    endfunction

    state_t              state_r, state_nxt;
    logic [FRAME_W-1:0]  sr_r, sr_nxt;
    logic [BAUD_W-1:0]   baud_cnt_r, baud_cnt_nxt;
    logic [3:0]          bit_cnt_r, bit_cnt_nxt;
    logic [BAUD_W-1:0]   div_r, div_nxt;
    logic                txrdy_r, txrdy_nxt;

    logic [FRAME_W-1:0]  frame_in_s;
    logic [BAUD_W-1:0]   div_in_s;
    logic                term_s;
    logic                last_s;

`ifdef UART_TX_HOLD_REG_EN
    logic [FRAME_W-1:0]  hold_frame_r, hold_frame_nxt;
    logic [BAUD_W-1:0]   hold_div_r, hold_div_nxt;
    logic                hold_valid_r, hold_valid_nxt;
`endif

    assign frame_in_s = build_frame(data, eight, pen, ohel);
    assign div_in_s   = (baud_div == DIV_ZERO) ? DIV_ONE : baud_div;
    assign term_s     = (baud_cnt_r == (div_r - DIV_ONE));
    assign last_s     = term_s && (bit_cnt_r == LAST_BIT);

    // Next-state, shifter, counters and ready flag.
    always_comb begin
        state_nxt    = state_r;
        sr_nxt       = sr_r;
        baud_cnt_nxt = baud_cnt_r;
        bit_cnt_nxt  = bit_cnt_r;
        div_nxt      = div_r;
        txrdy_nxt    = txrdy_r;
`ifdef UART_TX_HOLD_REG_EN
        hold_frame_nxt = hold_frame_r;
        hold_div_nxt   = hold_div_r;
        hold_valid_nxt = hold_valid_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (load && txrdy_r) begin
                    state_nxt    = ST_SHIFT;
                    sr_nxt       = frame_in_s;
                    baud_cnt_nxt = DIV_ZERO;
                    bit_cnt_nxt  = 4'd0;
                    div_nxt      = div_in_s;
`ifdef UART_TX_HOLD_REG_EN
                    // Holding register stays empty, so the CPU may queue another byte.
                    txrdy_nxt    = 1'b1;
`else
                    txrdy_nxt    = 1'b0;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (term_s) begin
                    sr_nxt       = {1'b1, sr_r[FRAME_W-1:1]};
                    bit_cnt_nxt  = bit_cnt_r + 4'd1;
                    baud_cnt_nxt = DIV_ZERO;
                    if (last_s) begin
`ifdef UART_TX_HOLD_REG_EN
                        if (hold_valid_r) begin
                            // Queued frame starts on the edge the stop bit ends.
                            sr_nxt         = hold_frame_r;
                            div_nxt        = hold_div_r;
                            bit_cnt_nxt    = 4'd0;
                            hold_valid_nxt = 1'b0;
                            txrdy_nxt      = 1'b1;
                        end else if (load) begin
                            sr_nxt      = frame_in_s;
                            div_nxt     = div_in_s;
                            bit_cnt_nxt = 4'd0;
                            txrdy_nxt   = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            txrdy_nxt = 1'b1;
                        end
`else
                        state_nxt = ST_IDLE;
                        txrdy_nxt = 1'b1;
`endif
                    end else begin
                        state_nxt = ST_SHIFT;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt_r + DIV_ONE;
                end
`ifdef UART_TX_HOLD_REG_EN
                // Capture a byte into the empty holding register mid-frame.
                if (load && !hold_valid_r && !last_s) begin
                    hold_frame_nxt = frame_in_s;
                    hold_div_nxt   = div_in_s;
                    hold_valid_nxt = 1'b1;
                    txrdy_nxt      = 1'b0;
                end else begin
                    hold_valid_nxt = hold_valid_nxt;
                end
`endif
            end
            default: begin
                state_nxt    = ST_IDLE;
                sr_nxt       = {FRAME_W{1'b1}};
                baud_cnt_nxt = DIV_ZERO;
                bit_cnt_nxt  = 4'd0;
                txrdy_nxt    = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            sr_r       <= {FRAME_W{1'b1}};
            baud_cnt_r <= DIV_ZERO;
            bit_cnt_r  <= 4'd0;
            div_r      <= DIV_ONE;
            txrdy_r    <= 1'b1;
`ifdef UART_TX_HOLD_REG_EN
            hold_frame_r <= {FRAME_W{1'b1}};
            hold_div_r   <= DIV_ONE;
            hold_valid_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt;
            sr_r       <= sr_nxt;
            baud_cnt_r <= baud_cnt_nxt;
            bit_cnt_r  <= bit_cnt_nxt;
            div_r      <= div_nxt;
            txrdy_r    <= txrdy_nxt;
`ifdef UART_TX_HOLD_REG_EN
            hold_frame_r <= hold_frame_nxt;
            hold_div_r   <= hold_div_nxt;
            hold_valid_r <= hold_valid_nxt;
`endif
        end
    end

    assign tx    = sr_r[0];
    assign txrdy = txrdy_r;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: a table of framing vectors with
// hand-computed expected bit streams, plus hand-written multi-cycle sequences
// (reset with load held, mid-frame load, mid-frame reset, queued frame).
module tb_uart_tx_sequencer;

`ifdef UART_TX_HOLD_REG_EN
    localparam logic HOLD = 1'b1;
`else
    localparam logic HOLD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        load;
    logic [7:0]  data;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [19:0] baud_div;
    logic        tx;
    logic        txrdy;

    int n_cmp;
    int n_bad;

    uart_tx_sequencer #(.BAUD_W(20), .FRAME_W(11)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data     (data),
        .eight    (eight),
        .pen      (pen),
        .ohel     (ohel),
        .baud_div (baud_div),
        .tx       (tx),
        .txrdy    (txrdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        e;
        logic        p;
        logic        o;
        logic [19:0] div;
        logic [10:0] exp; // exp[k] = k-th bit on the wire
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse load for one edge; returns #1 after the accept edge.
    task automatic send_start(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic [19:0] div);
        data = d; eight = e; pen = p; ohel = o; baud_div = div;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Checks 11 bit periods starting #1 after the edge the start bit begins.
    task automatic check_frame(input string name, input logic [10:0] exp, input int div,
                               input logic exp_rdy, input logic inject);
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("%s_bit%0d", name, k), {31'd0, tx}, {31'd0, exp[k]});
            chk($sformatf("%s_rdy%0d", name, k), {31'd0, txrdy}, {31'd0, exp_rdy});
            if (inject && k == 3) begin
                data = 8'h55; eight = 1'b0; pen = 1'b1; ohel = 1'b1; baud_div = 20'd1;
                load = 1'b1;
                tick();
                load = 1'b0;
                repeat (div - 1) tick();
            end else begin
                repeat (div) tick();
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; load = 1'b1; data = 8'hFF;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud_div = 20'd4;

        // A5 8N1, 03 7E1, 01 8O1, FF 7N1 div0, 80 8E, 7F 7O, 81 8E, 80 7N.
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 20'd4, 11'b11101001010};
        vecs[1] = '{8'h03, 1'b0, 1'b1, 1'b0, 20'd1, 11'b11000000110};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 1'b1, 20'd2, 11'b10000000010};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 20'd0, 11'b11111111110};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 20'd3, 11'b11100000000};
        vecs[5] = '{8'h7F, 1'b0, 1'b1, 1'b1, 20'd2, 11'b11011111110};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 1'b0, 20'd1, 11'b10100000010};
        vecs[7] = '{8'h80, 1'b0, 1'b0, 1'b0, 20'd2, 11'b11100000000};

        // Reset held 3 cycles with load high.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_tx%0d", i), {31'd0, tx}, 32'd1);
            chk($sformatf("rst_rdy%0d", i), {31'd0, txrdy}, 32'd1);
        end
        reset = 1'b0; load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("post_rst_tx%0d", i), {31'd0, tx}, 32'd1);
        end
        chk("post_rst_rdy", {31'd0, txrdy}, 32'd1);

        // Table of frames.
        for (int i = 0; i < 8; i++) begin
            int eff;
            eff = (vecs[i].div == 20'd0) ? 1 : int'(vecs[i].div);
            send_start(vecs[i].d, vecs[i].e, vecs[i].p, vecs[i].o, vecs[i].div);
            check_frame($sformatf("v%0d", i), vecs[i].exp, eff, HOLD, 1'b0);
            chk($sformatf("v%0d_end_tx", i), {31'd0, tx}, 32'd1);
            chk($sformatf("v%0d_end_rdy", i), {31'd0, txrdy}, 32'd1);
            tick();
        end

`ifndef UART_TX_HOLD_REG_EN
        // Load and config changes mid-frame are ignored.
        send_start(8'hA5, 1'b1, 1'b0, 1'b0, 20'd4);
        check_frame("midload", 11'b11101001010, 4, 1'b0, 1'b1);
        chk("midload_end_rdy", {31'd0, txrdy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("midload_idle%0d", i), {31'd0, tx}, 32'd1);
        end
`endif

        // Reset during bit 5 aborts the frame on the same edge.
        send_start(8'hA5, 1'b1, 1'b0, 1'b0, 20'd4);
        repeat (20) tick();
        chk("abort_bit5", {31'd0, tx}, 32'd0);
        chk("abort_rdy_before", {31'd0, txrdy}, {31'd0, HOLD});
        reset = 1'b1;
        tick();
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_rdy", {31'd0, txrdy}, 32'd1);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort_idle%0d", i), {31'd0, tx}, 32'd1);
        end

        // Frame after abort runs normally.
        send_start(8'h03, 1'b0, 1'b1, 1'b0, 20'd1);
        check_frame("after_abort", 11'b11000000110, 1, HOLD, 1'b0);
        chk("after_abort_end", {31'd0, tx}, 32'd1);

`ifdef UART_TX_HOLD_REG_EN
        // Queued 3C frame follows A5 stop bit with no idle gap.
        tick();
        send_start(8'hA5, 1'b1, 1'b0, 1'b0, 20'd2);
        chk("q_a5_bit0", {31'd0, tx}, 32'd0);
        chk("q_rdy_after_first", {31'd0, txrdy}, 32'd1);
        data = 8'h3C; load = 1'b1;
        tick();
        load = 1'b0;
        chk("q_rdy_after_second", {31'd0, txrdy}, 32'd0);
        tick();
        for (int k = 1; k < 11; k++) begin
            logic [10:0] a5;
            a5 = 11'b11101001010;
            chk($sformatf("q_a5_bit%0d", k), {31'd0, tx}, {31'd0, a5[k]});
            chk($sformatf("q_a5_rdy%0d", k), {31'd0, txrdy}, 32'd0);
            repeat (2) tick();
        end
        check_frame("q_3c", 11'b11001111000, 2, 1'b1, 1'b0);
        chk("q_end_tx", {31'd0, tx}, 32'd1);
        chk("q_end_rdy", {31'd0, txrdy}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
